// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_pkg;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_JUMP   = 2'b01;
    localparam logic [1:0] PC_RET    = 2'b10;
    localparam logic [1:0] PC_BRANCH = 2'b11;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack with a saturating occupancy count and sticky
// overflow/underflow flags. When full, a push overwrites the oldest entry.
module return_addr_stack #(
    parameter int PC_W      = 12,
    parameter int RAS_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [PC_W-1:0]              push_addr_i,
    output logic [PC_W-1:0]              top_o,
    output logic                         empty_o,
    output logic [$clog2(RAS_DEPTH):0]   count_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  stack_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic             full, empty;

    assign full  = (count_q == CNT_W'(RAS_DEPTH));
    assign empty = (count_q == '0);

    // ptr_q always names the top slot; the power-of-two depth makes the
    // pointer wrap for free, which is what recycles the oldest entry.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        if (push_i && pop_i && !empty) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q;
        end else if (push_i) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q + 1'b1;
            ptr_d  = ptr_q + 1'b1;
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
            if (pop_i) begin
                unf_d = 1'b1;
            end
        end else if (pop_i) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                ptr_d   = ptr_q - 1'b1;
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entry storage needs no reset: occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            stack_q[wr_idx] <= push_addr_i;
        end
    end

    assign top_o       = stack_q[ptr_q];
    assign empty_o     = empty;
    assign count_o     = count_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, IF pipeline register, redirect target mux,
// RUN/HALT control and the return-address stack.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                PC_W      = 12,
    parameter int                INST_W    = 19,
    parameter int                RAS_DEPTH = 8,
    parameter logic [PC_W-1:0]   RESET_PC  = '0,
    parameter logic [INST_W-1:0] HALT_WORD = '1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic [1:0]                 pc_src,
    input  logic [PC_W-1:0]            jump_target,
    input  logic [PC_W-1:0]            branch_target,
    input  logic                       ras_push,
    input  logic                       ras_pop,
    output logic [PC_W-1:0]            imem_addr,
    input  logic [INST_W-1:0]          imem_data,
    output logic [INST_W-1:0]          if_inst,
    output logic [PC_W-1:0]            if_pc,
    output logic                       if_valid,
    output logic                       halted,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_overflow,
    output logic                       ras_underflow
);

    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] if_inst_q, if_inst_d;
    logic [PC_W-1:0]   if_pc_q, if_pc_d;
    logic              if_valid_q, if_valid_d;
    logic [PC_W-1:0]   pc_plus1;
    logic [PC_W-1:0]   redirect_target;
    logic [PC_W-1:0]   ras_top;
    logic              ras_empty;
    logic              run;
    logic              push_eff, pop_eff;

    assign run      = (state_q == FS_RUN);
    assign pc_plus1 = pc_q + 1'b1;
    // A stalled ID stage re-presents the same call, so its push waits.
    assign push_eff = run && ras_push && !stall;
    assign pop_eff  = run && ras_pop;

    return_addr_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_eff),
        .pop_i       (pop_eff),
        .push_addr_i (if_pc_q),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .count_o     (ras_count),
        .overflow_o  (ras_overflow),
        .underflow_o (ras_underflow)
    );

    always_comb begin
        redirect_target = pc_plus1;
        case (pc_src)
            PC_JUMP:   redirect_target = jump_target;
            PC_BRANCH: redirect_target = branch_target;
            PC_RET:    redirect_target = ras_empty ? RESET_PC : ras_top;
            default:   redirect_target = pc_plus1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_inst_d  = if_inst_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        case (state_q)
            FS_RUN: begin
                if (pc_src != PC_SEQ) begin
                    pc_d       = redirect_target;
                    if_inst_d  = '0;
                    if_valid_d = 1'b0;
                end else if (!stall) begin
                    if_inst_d  = imem_data;
                    if_pc_d    = pc_plus1;
                    if_valid_d = 1'b1;
                    if (imem_data == HALT_WORD) begin
                        state_d = FS_HALT;
                    end else begin
                        pc_d = pc_plus1;
                    end
                end
            end
            FS_HALT: begin
                if_inst_d  = '0;
                if_valid_d = 1'b0;
            end
            default: state_d = FS_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FS_RUN;
            pc_q       <= RESET_PC;
            if_inst_q  <= '0;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_inst_q  <= if_inst_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign if_inst   = if_inst_q;
    assign if_pc     = if_pc_q;
    assign if_valid  = if_valid_q;
    assign halted    = (state_q == FS_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected IF/PC snapshots are queued when a
// step is driven and compared one edge later.
module tb_fetch_unit;

    localparam int PC_W   = 12;
    localparam int INST_W = 19;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int W      = INST_W + PC_W + 1 + PC_W;

    logic              clk;
    logic              rst;
    logic              stall;
    logic [1:0]        pc_src;
    logic [PC_W-1:0]   jump_target;
    logic [PC_W-1:0]   branch_target;
    logic              ras_push;
    logic              ras_pop;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_data;
    logic [INST_W-1:0] if_inst;
    logic [PC_W-1:0]   if_pc;
    logic              if_valid;
    logic              halted;
    logic [CNT_W-1:0]  ras_count;
    logic              ras_overflow;
    logic              ras_underflow;

    logic              halt_en;
    logic [PC_W-1:0]   halt_addr;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] msk_q[$];
    string        tag_q[$];

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit #(
        .PC_W      (PC_W),
        .INST_W    (INST_W),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .pc_src        (pc_src),
        .jump_target   (jump_target),
        .branch_target (branch_target),
        .ras_push      (ras_push),
        .ras_pop       (ras_pop),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .if_inst       (if_inst),
        .if_pc         (if_pc),
        .if_valid      (if_valid),
        .halted        (halted),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: word k at address k, optional halt word at halt_addr
    always_comb begin
        if (halt_en && imem_addr == halt_addr) imem_data = '1;
        else                                   imem_data = INST_W'(imem_addr);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Queue expectation {if_inst, if_pc, if_valid, imem_addr} for the next edge.
    task automatic expect_out(input string tag, input int inst, input int ipc,
                              input int valid, input int addr, input bit chk_pc);
        logic [W-1:0] m;
        m = '1;
        if (!chk_pc) m[PC_W+1 +: PC_W] = '0;
        exp_q.push_back({INST_W'(inst), PC_W'(ipc), 1'(valid), PC_W'(addr)});
        msk_q.push_back(m);
        tag_q.push_back(tag);
    endtask

    task automatic tick();
        logic [W-1:0] e, m, o;
        string        t;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            t = tag_q.pop_front();
            o = {if_inst, if_pc, if_valid, imem_addr};
            chk(t, 64'(o & m), 64'(e & m));
        end
    endtask

    task automatic step(input string tag, input int inst, input int ipc,
                        input int valid, input int addr, input bit chk_pc);
        expect_out(tag, inst, ipc, valid, addr, chk_pc);
        tick();
    endtask

    // Land if_pc on v via a jump to v-1, then push it.
    task automatic push_val(input int v, input int exp_cnt, input bit exp_ovf);
        pc_src = 2'b01;
        jump_target = PC_W'(v - 1);
        step("push_jump", 0, 0, 0, v - 1, 1'b0);
        pc_src = 2'b00;
        step("push_seq", v - 1, v, 1, v, 1'b1);
        ras_push = 1'b1;
        step("push_edge", v, v + 1, 1, v + 1, 1'b1);
        ras_push = 1'b0;
        chk("ras_count_push", 64'(ras_count), 64'(exp_cnt));
        chk("ras_overflow_push", 64'(ras_overflow), 64'(exp_ovf));
    endtask

    initial begin
        int ret_tgt[5];
        int ret_cnt[5];
        logic [INST_W-1:0] hw;
        hw = '1;
        ret_tgt = '{32'h055, 32'h044, 32'h033, 32'h022, 32'h000};
        ret_cnt = '{3, 2, 1, 0, 0};

        rst = 1'b0; stall = 1'b0; pc_src = 2'b00;
        jump_target = '0; branch_target = '0;
        ras_push = 1'b0; ras_pop = 1'b0;
        halt_en = 1'b0; halt_addr = 12'h007;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_addr", 64'(imem_addr), 64'(0));
        chk("rst_if_reg", 64'({if_inst, if_pc, if_valid}), 64'(0));
        chk("rst_halted", 64'(halted), 64'(0));
        chk("rst_ras_count", 64'(ras_count), 64'(0));
        chk("rst_ras_flags", 64'({ras_overflow, ras_underflow}), 64'(0));
        rst = 1'b1;

        // sequential fetch, word k one cycle behind address k
        for (int k = 1; k <= 5; k++) begin
            step($sformatf("seq_%0d", k), k - 1, k, 1, k, 1'b1);
        end

        // stall holds PC=5 and the IF register; branch overrides stall
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step("stall_hold", 4, 5, 1, 5, 1'b1);
        end
        pc_src = 2'b11;
        branch_target = 12'h040;
        step("branch_in_stall", 0, 0, 0, 12'h040, 1'b0);
        stall = 1'b0;
        pc_src = 2'b00;
        step("after_branch", 12'h040, 12'h041, 1, 12'h041, 1'b1);

        // RAS depth 4: five pushes overflow, oldest (0x011) lost
        push_val(12'h011, 1, 1'b0);
        push_val(12'h022, 2, 1'b0);
        push_val(12'h033, 3, 1'b0);
        push_val(12'h044, 4, 1'b0);
        push_val(12'h055, 4, 1'b1);

        pc_src = 2'b10;
        ras_pop = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step($sformatf("ret_%0d", k), 0, 0, 0, ret_tgt[k], 1'b0);
            chk($sformatf("ret_count_%0d", k), 64'(ras_count), 64'(ret_cnt[k]));
            chk($sformatf("ret_underflow_%0d", k), 64'(ras_underflow), 64'(k == 4));
        end
        chk("overflow_sticky", 64'(ras_overflow), 64'(1));
        ras_pop = 1'b0;
        pc_src = 2'b00;

        // simultaneous push/pop: return to old top, new top replaces it
        push_val(12'h020, 1, 1'b1);
        pc_src = 2'b01;
        jump_target = 12'h00F;
        step("pp_jump", 0, 0, 0, 12'h00F, 1'b0);
        pc_src = 2'b00;
        step("pp_seq", 12'h00F, 12'h010, 1, 12'h010, 1'b1);
        ras_push = 1'b1;
        ras_pop = 1'b1;
        pc_src = 2'b10;
        step("push_pop_ret", 0, 0, 0, 12'h020, 1'b0);
        chk("push_pop_count", 64'(ras_count), 64'(1));
        ras_push = 1'b0;
        step("pop_new_top", 0, 0, 0, 12'h010, 1'b0);
        chk("pop_new_top_count", 64'(ras_count), 64'(0));
        ras_pop = 1'b0;
        pc_src = 2'b00;

        // PC wrap from all ones
        pc_src = 2'b01;
        jump_target = 12'hFFF;
        step("wrap_jump", 0, 0, 0, 12'hFFF, 1'b0);
        pc_src = 2'b00;
        step("wrap_seq", 12'hFFF, 12'h000, 1, 12'h000, 1'b1);

        // halt word at address 7
        halt_en = 1'b1;
        pc_src = 2'b01;
        jump_target = 12'h006;
        step("halt_jump", 0, 0, 0, 6, 1'b0);
        pc_src = 2'b00;
        step("pre_halt", 6, 7, 1, 7, 1'b1);
        chk("pre_halt_halted", 64'(halted), 64'(0));
        step("halt_latch", int'(hw), 8, 1, 7, 1'b1);
        chk("halt_halted", 64'(halted), 64'(1));
        pc_src = 2'b01;
        jump_target = 12'h100;
        step("halt_jump_ignored", 0, 0, 0, 7, 1'b0);
        chk("halt_still_halted", 64'(halted), 64'(1));
        pc_src = 2'b00;
        stall = 1'b1;
        step("halt_stall", 0, 0, 0, 7, 1'b0);
        stall = 1'b0;

        // asynchronous reset mid-operation
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_addr", 64'(imem_addr), 64'(0));
        chk("async_rst_halted", 64'(halted), 64'(0));
        chk("async_rst_if_reg", 64'({if_inst, if_pc, if_valid}), 64'(0));
        chk("async_rst_ras", 64'({ras_count, ras_overflow, ras_underflow}), 64'(0));
        halt_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        step("resume", 0, 1, 1, 1, 1'b1);

        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the pipelined core. It owns the PC register, the IF pipeline register and a return-address stack (RAS), and adds stall, flush-on-redirect and halt handling. Every register is updated on `posedge clk`. Decode and execute consume its outputs; the EX stage drives its redirect inputs.

## Interface
- `PC_W`, default 12: PC and address width.
- `INST_W`, default 19: instruction width.
- `RAS_DEPTH`, default 8: RAS entries, a power of two, at least 2.
- `RESET_PC`, default 0: PC after reset; also the fallback return target.
- `HALT_WORD`, default all ones (`INST_W` bits): halt opcode.

Ports:
- `clk`  in  1  clock; every register updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  hazard stall; holds PC and the IF register.
- `pc_src`  in  2  EX redirect select: 00 sequential, 01 jump, 10 return, 11 branch.
- `jump_target`  in  `PC_W`  target for pc_src 01.
- `branch_target`  in  `PC_W`  target for pc_src 11.
- `ras_push`  in  1  call in ID: push `if_pc`.
- `ras_pop`  in  1  return in EX; asserted together with pc_src 10.
- `imem_addr`  out  `PC_W`  instruction memory address, equal to PC.
- `imem_data`  in  `INST_W`  combinational instruction memory read data.
- `if_inst`  out  `INST_W`  IF register instruction.
- `if_pc`  out  `PC_W`  IF register: fetch address + 1.
- `if_valid`  out  1  IF register holds a real instruction.
- `halted`  out  1  fetch is frozen in the HALT state.
- `ras_count`  out  `$clog2(RAS_DEPTH)+1`  current RAS occupancy.
- `ras_overflow`  out  1  sticky: a push occurred while the RAS was full.
- `ras_underflow`  out  1  sticky: a pop occurred while the RAS was empty.

## Operation
- Two-state FSM: RUN and HALT. The only exit from HALT is reset.
- RUN, one action per cycle, highest priority first:
  1. Redirect (pc_src ≠ 00). PC ← target. Return target = RAS top, or `RESET_PC` if the RAS is empty. The IF register is flushed to a bubble: inst 0, valid 0. Redirect overrides stall.
  2. Stall. PC and the IF register hold.
  3. Halt fetch (imem_data == HALT_WORD). IF register ← {HALT_WORD, PC+1, valid 1}. PC holds. FSM → HALT.
  4. Otherwise PC ← PC+1 and IF register ← {imem_data, PC+1, valid 1}.
- HALT:
  - PC frozen; redirects and stalls are ignored.
  - IF register becomes a bubble on the first HALT cycle and stays one.
  - `halted` = 1.
- PC arithmetic is modulo 2^`PC_W`. PC+1 from all ones wraps to 0.
- RAS is a circular buffer with `ras_count` saturating at `RAS_DEPTH`.
  - Push when full: overwrite the oldest entry, count stays at `RAS_DEPTH`, set `ras_overflow`.
  - Pop when empty: count stays 0, set `ras_underflow`, target `RESET_PC`.
  - Push and pop in the same cycle: replace the top entry, count unchanged. The pop target is the entry before the replacement.
  - A push during stall is ignored, because ID is held. A pop is honoured, because it comes with a redirect.
  - In HALT, push and pop are ignored.

## Timing
- Reset values: PC = `RESET_PC`, if_inst = 0, if_pc = 0, if_valid = 0, halted = 0, RAS empty, count 0, both sticky flags 0, FSM RUN.
- `imem_addr` is combinational from PC. `if_inst` appears one cycle after the PC presents it.
- Redirect latency: the target is on `imem_addr` in the cycle after pc_src is sampled, and the bubble appears at the same edge. This gives a fixed 1-bubble penalty from this block.
- `halted` rises at the edge that latches HALT_WORD.
- Reset asserted mid-operation clears everything immediately. Fetch resumes at `RESET_PC` on the first edge after release.

## Structure
- Package `fetch_pkg`:
  - pc_src constants: `PC_SEQ` = 00, `PC_JUMP` = 01, `PC_RET` = 10, `PC_BRANCH` = 11.
  - FSM enum: `FS_RUN`, `FS_HALT`.
- Sub-module `return_addr_stack`, parametrised on `PC_W` and `RAS_DEPTH`. It contains the circular pointer, count, top output, and overflow/underflow flags.
- The top level holds the FSM, PC and IF register, and target mux.

## Test plan
- Reset release, no stall, memory returns word k at address k → `if_inst` = 0, 1, 2… one cycle behind `imem_addr`; `if_pc` = addr+1.
- PC = 5, `stall` high for 3 cycles → PC stays 5 and `if_inst` is held. Assert pc_src = 11 with branch_target = 0x040 during the stall → next `imem_addr` = 0x040, if_valid = 0 for one cycle.
- RAS_DEPTH = 4: push 0x011, 0x022, 0x033, 0x044, 0x055 → count 4, `ras_overflow` = 1. Five pop+return redirects → targets 0x055, 0x044, 0x033, 0x022, then `RESET_PC` with `ras_underflow` = 1.
- Push 0x010 and pop in the same cycle with top = 0x020 → redirect to 0x020, new top = 0x010, count unchanged.
- HALT_WORD at address 7 → `halted` = 1, PC stays 7. A later jump redirect is ignored. rst low → PC = 0, halted = 0.
- PC_W = 4, PC = 0xF, sequential → next PC = 0x0, `if_pc` = 0x0.
